// File: rtl/mdu_seq_if.sv
// Operand, handshake and HI/LO result bundle between the pipeline and the
// iterative multiply/divide sequencer.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULTU/MULT/DIVU/DIV engine: one bit per cycle on operand
// magnitudes, sign fix-up in a final cycle, owns the HI/LO registers.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   d_reg, a_raw_reg, hi_reg, lo_reg;
  logic               is_div_reg, neg_reg, rem_neg_reg, bzero_reg, done_reg;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, prod;
  logic               div_ok;
  logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.op[0] && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (bus.op[0] && bus.b[WIDTH-1]) b_mag = -bus.b;
  end

  // Multiply: multiplier sits in the low half and shifts out as the product
  // grows into the high half. Divide: dividend bits shift out of the low half
  // into the remainder while quotient bits shift in behind them.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, d_reg};
    mul_next  = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                           : {1'b0, acc_reg[2*WIDTH-1:1]};
    div_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d_reg};
    div_ok    = ~div_diff[WIDTH];
  end

  always_comb begin
    prod   = neg_reg ? -acc_reg : acc_reg;
    quot   = neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem    = rem_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_reg) begin
      // Divide by zero reports the raw dividend, not a sign-corrected one.
      fix_hi = bzero_reg ? a_raw_reg : rem;
      fix_lo = bzero_reg ? '1 : quot;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt_reg == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      d_reg       <= '0;
      a_raw_reg   <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      is_div_reg  <= 1'b0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      bzero_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            is_div_reg  <= bus.op[1];
            neg_reg     <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg_reg <= bus.op[0] & bus.a[WIDTH-1];
            bzero_reg   <= (bus.b == '0);
            a_raw_reg   <= bus.a;
            d_reg       <= bus.op[1] ? b_mag : a_mag;
            acc_reg     <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wdata;
            if (bus.wr_lo) lo_reg <= bus.wdata;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div_reg) begin
            rem_reg            <= div_ok ? div_diff : div_shift;
            acc_reg[WIDTH-1:0] <= {acc_reg[WIDTH-2:0], div_ok};
          end else begin
            acc_reg <= mul_next;
          end
        end
        FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS datapath.
- Replaces single-cycle MULTU/DIVU with a one-bit-per-cycle shift/add and restoring-divide engine.
- Owns the HI/LO registers and raises busy so the pipeline controller stalls dependent MFHI/MFLO and further MDU ops.
- Sits beside the ALU, fed from the same operand buses.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- wr_hi  input  1  MTHI strobe
- wr_lo  input  1  MTLO strobe
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  high while an operation is in flight (state != IDLE)
- done  output  1  one-cycle pulse; HI/LO hold the new result
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0.
  - Takes effect immediately, including mid-operation. The in-flight op is aborted and done is never pulsed for it.
- States:
  - IDLE: start=1 in cycle T latches |a| and |b| (for signed ops), the sign bits, op, and the b==0 flag. Clears counter. Next state CALC.
  - CALC: exactly WIDTH cycles (T+1..T+WIDTH), one bit per cycle.
    - Multiply: shift-add on a 2*WIDTH accumulator.
    - Divide: restoring step on a WIDTH+1 remainder.
    - Counter 0..WIDTH-1; leaves to FIX when counter==WIDTH-1.
  - FIX: one cycle (T+WIDTH+1). Applies sign correction, writes hi/lo, sets done for the next cycle. Next state IDLE.
- Timing:
  - busy high T+1..T+WIDTH+1 (WIDTH+1 cycles).
  - done high at T+WIDTH+2 only; new hi/lo visible at T+WIDTH+2.
  - Total latency WIDTH+2 cycles (34 at default).
- Back-to-back: start asserted in the done cycle is accepted, because state is IDLE.
- start while busy: ignored and not queued. The pipeline must hold the request until busy=0.
- wr_hi / wr_lo:
  - In IDLE, write wdata to hi/lo; visible next cycle. Both may be written in the same cycle.
  - While busy: ignored.
  - In IDLE with start=1 in the same cycle: start wins and the writes are discarded.
- Sign rules:
  - MULT: 2*WIDTH product negated when sign(a)!=sign(b).
  - DIV: quotient negated when signs differ; remainder takes the sign of a.
  - Unsigned ops: no correction.
- Divide by zero (both DIVU and DIV, fixed behaviour):
  - lo = all ones; hi = original a, uncorrected.
  - Still takes the full WIDTH+2 latency.
- DIV overflow: most-negative / -1 gives lo=0x80000000, hi=0, which falls out of the magnitude math.
- Operand inputs are don't-care after the start cycle; results depend only on latched values.
- hi/lo change only in FIX, on MTHI/MTLO in IDLE, or on reset.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at T:
   - busy=1 at T+1..T+33.
   - done=1 at T+34 only.
   - hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. Division results:
   - DIVU a=100 b=7 -> lo=14, hi=2.
   - DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. Boundary divides:
   - DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, done at T+34.
   - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Handshake and MTHI/MTLO:
   - Second start at T+5 with different operands is ignored; the result matches the first op.
   - wr_hi during busy leaves hi unchanged.
   - wr_lo wdata=0xA5A5A5A5 in IDLE gives lo=0xA5A5A5A5 next cycle.
   - start in the done cycle begins a new op; busy=1 the next cycle.
6. rst_n driven low at T+10 mid-CALC -> busy=0, hi=0, lo=0 immediately. done never pulses. After release, a fresh MULTU 6*7 gives lo=42, hi=0.
